// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared defaults and the scoreboard update-request type for
//                the regfile_sb register file.
//  Contents    : XLEN_DEF, NREG_DEF, NRD_MAX, SB_AW, sb_req_t
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int NRD_MAX  = 4;

    // Address field width of a scoreboard request; wide enough for NREG <= 256.
    localparam int SB_AW = 8;

    // One scoreboard update: when valid, the addressed pending bit takes 'set'.
    typedef struct packed {
        logic             valid;
        logic             set;
        logic [SB_AW-1:0] addr;
    } sb_req_t;

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_scoreboard
//  Description : Pending-write bitmap. Issue sets a bit, writeback clears it,
//                flush clears everything. Bit 0 is never pending.
//  Ports       : clk, reset (async, active-high), flush, iss/iss_a (set),
//                we3/a3 (clear), pend (bitmap out)
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            iss,
    input  logic [AW-1:0]   iss_a,
    input  logic            we3,
    input  logic [AW-1:0]   a3,
    output logic [NREG-1:0] pend
);

    sb_req_t         w_set_req;
    sb_req_t         w_clr_req;
    logic [NREG-1:0] r_pend;
    logic [NREG-1:0] w_pend_next;

    always_comb begin
        w_set_req       = '0;
        w_set_req.valid = iss;
        w_set_req.set   = 1'b1;
        w_set_req.addr  = SB_AW'(iss_a);

        w_clr_req       = '0;
        w_clr_req.valid = we3;
        w_clr_req.set   = 1'b0;
        w_clr_req.addr  = SB_AW'(a3);
    end

    // The clear is applied before the set, so a newly issued producer wins
    // over an older producer's writeback to the same register.
    always_comb begin
        w_pend_next = r_pend;
        if (flush) begin
            w_pend_next = '0;
        end else begin
            for (int n = 1; n < NREG; n++) begin
                if (w_clr_req.valid && (w_clr_req.addr == SB_AW'(n)))
                    w_pend_next[n] = w_clr_req.set;
                if (w_set_req.valid && (w_set_req.addr == SB_AW'(n)))
                    w_pend_next[n] = w_set_req.set;
            end
        end
        w_pend_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_pend <= '0;
        else
            r_pend <= w_pend_next;
    end

    assign pend = r_pend;

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_sb
//  Description : Multi-read-port register file with write-through bypass and
//                an integrated pending-write scoreboard. x0 reads as zero and
//                is never pending.
//  Ports       : clk, reset (async, active-high)
//                ra[NRD]/rd[NRD]/rbusy[NRD] - read address/data/stall flag
//                we3/a3/wd3                 - writeback
//                iss/iss_a                  - destination issue
//                flush                      - clear all pending bits
//                pend                       - pending bitmap
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int XLEN = XLEN_DEF,
    parameter  int NREG = NREG_DEF,
    parameter  int NRD  = 2,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NRD-1:0][AW-1:0]    ra,
    output logic [NRD-1:0][XLEN-1:0]  rd,
    output logic [NRD-1:0]            rbusy,
    input  logic                      we3,
    input  logic [AW-1:0]             a3,
    input  logic [XLEN-1:0]           wd3,
    input  logic                      iss,
    input  logic [AW-1:0]             iss_a,
    input  logic                      flush,
    output logic [NREG-1:0]           pend
);

    // x0 has no storage.
    logic [XLEN-1:0] r_regs [1:NREG-1];
    logic [NREG-1:0] w_pend;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 1; n < NREG; n++)
                r_regs[n] <= '0;
        end else begin
            for (int n = 1; n < NREG; n++)
                if (we3 && (a3 == AW'(n)))
                    r_regs[n] <= wd3;
        end
    end

    regfile_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_scoreboard (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .iss   (iss),
        .iss_a (iss_a),
        .we3   (we3),
        .a3    (a3),
        .pend  (w_pend)
    );

    assign pend = w_pend;

    for (genvar i = 0; i < NRD; i++) begin : g_port
        logic w_zero;
        logic w_hit;

        assign w_zero = (ra[i] == '0);
        // Bypass is suppressed under reset so rd reads zero immediately.
        assign w_hit  = we3 && !reset && (a3 == ra[i]);

        assign rd[i]    = (reset || w_zero) ? '0 :
                          w_hit             ? wd3 :
                                              r_regs[ra[i]];

        // A same-cycle writeback satisfies the operand through the bypass.
        assign rbusy[i] = w_pend[ra[i]] && !w_hit && !w_zero;
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_sb
//  Description : Self-checking bench for regfile_sb (NRD=4). Directed vectors,
//                one per cycle, each checked before the next rising edge,
//                followed by an asynchronous reset pulse between edges.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 4;
    localparam int AW   = 5;
    localparam int NVEC = 17;

    logic                     clk;
    logic                     reset;
    logic [NRD-1:0][AW-1:0]   ra;
    logic [NRD-1:0][XLEN-1:0] rd;
    logic [NRD-1:0]           rbusy;
    logic                     we3;
    logic [AW-1:0]            a3;
    logic [XLEN-1:0]          wd3;
    logic                     iss;
    logic [AW-1:0]            iss_a;
    logic                     flush;
    logic [NREG-1:0]          pend;

    int checks;
    int errors;

    regfile_sb #(
        .XLEN (XLEN),
        .NREG (NREG),
        .NRD  (NRD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ra    (ra),
        .rd    (rd),
        .rbusy (rbusy),
        .we3   (we3),
        .a3    (a3),
        .wd3   (wd3),
        .iss   (iss),
        .iss_a (iss_a),
        .flush (flush),
        .pend  (pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic                     rst;
        logic                     we3;
        logic [AW-1:0]            a3;
        logic [XLEN-1:0]          wd3;
        logic                     iss;
        logic [AW-1:0]            iss_a;
        logic                     flush;
        logic [NRD-1:0][AW-1:0]   ra;
        logic [NRD-1:0][XLEN-1:0] exp_rd;
        logic [NRD-1:0]           exp_busy;
        logic [NREG-1:0]          exp_pend;
    } vec_t;

    vec_t vt [NVEC];

    function automatic vec_t mk(input logic rst_i, input logic we_i,
                                input int a_i, input logic [XLEN-1:0] wd_i,
                                input logic iss_i, input int ia_i,
                                input logic fl_i,
                                input int r0, input int r1, input int r2, input int r3,
                                input logic [XLEN-1:0] d0, input logic [XLEN-1:0] d1,
                                input logic [XLEN-1:0] d2, input logic [XLEN-1:0] d3,
                                input logic [NRD-1:0] busy_i,
                                input logic [NREG-1:0] pend_i);
        vec_t v;
        v.rst       = rst_i;
        v.we3       = we_i;
        v.a3        = AW'(a_i);
        v.wd3       = wd_i;
        v.iss       = iss_i;
        v.iss_a     = AW'(ia_i);
        v.flush     = fl_i;
        v.ra[0]     = AW'(r0);
        v.ra[1]     = AW'(r1);
        v.ra[2]     = AW'(r2);
        v.ra[3]     = AW'(r3);
        v.exp_rd[0] = d0;
        v.exp_rd[1] = d1;
        v.exp_rd[2] = d2;
        v.exp_rd[3] = d3;
        v.exp_busy  = busy_i;
        v.exp_pend  = pend_i;
        return v;
    endfunction

    task automatic check_outputs(input string name,
                                 input logic [NRD-1:0][XLEN-1:0] e_rd,
                                 input logic [NRD-1:0] e_busy,
                                 input logic [NREG-1:0] e_pend);
        checks++;
        if (rd !== e_rd) begin
            errors++;
            $display("FAIL %s rd: got %h expected %h", name, rd, e_rd);
        end
        checks++;
        if (rbusy !== e_busy) begin
            errors++;
            $display("FAIL %s rbusy: got %b expected %b", name, rbusy, e_busy);
        end
        checks++;
        if (pend !== e_pend) begin
            errors++;
            $display("FAIL %s pend: got %h expected %h", name, pend, e_pend);
        end
    endtask

    initial begin
        logic [NRD-1:0][XLEN-1:0] e_rd;

        checks = 0;
        errors = 0;
        reset  = 1'b1;
        ra     = '0;
        we3    = 1'b0;
        a3     = '0;
        wd3    = '0;
        iss    = 1'b0;
        iss_a  = '0;
        flush  = 1'b0;

        //          rst we a3 wd3     iss ia fl  ra0..ra3      rd0..rd3                                   busy     pend
        // reset holds everything at zero, writes/issues ignored
        vt[0]  = mk(1, 1, 5, 32'hDEAD, 1, 5, 0,  5, 5, 0, 1,   0, 0, 0, 0,                                4'b0000, 32'h0);
        vt[1]  = mk(0, 0, 0, 0,        0, 0, 0,  5, 5, 5, 5,   0, 0, 0, 0,                                4'b0000, 32'h0);
        // write 42 to x1 (bypass visible same cycle), then x0 write discarded
        vt[2]  = mk(0, 1, 1, 42,       0, 0, 0,  1, 2, 0, 1,   42, 0, 0, 42,                              4'b0000, 32'h0);
        vt[3]  = mk(0, 1, 0, 99,       1, 0, 0,  1, 0, 0, 0,   42, 0, 0, 0,                               4'b0000, 32'h0);
        // all four ports read x7 through the bypass, then from storage
        vt[4]  = mk(0, 1, 7, 32'h1234, 0, 0, 0,  7, 7, 7, 7,   32'h1234, 32'h1234, 32'h1234, 32'h1234,    4'b0000, 32'h0);
        vt[5]  = mk(0, 0, 0, 0,        0, 0, 0,  7, 7, 1, 0,   32'h1234, 32'h1234, 42, 0,                 4'b0000, 32'h0);
        // scoreboard lifecycle on x3
        vt[6]  = mk(0, 0, 0, 0,        1, 3, 0,  0, 3, 0, 0,   0, 0, 0, 0,                                4'b0000, 32'h0);
        vt[7]  = mk(0, 0, 0, 0,        0, 0, 0,  0, 3, 3, 1,   0, 0, 0, 42,                               4'b0110, 32'h8);
        vt[8]  = mk(0, 1, 3, 32'h33,   0, 0, 0,  0, 3, 0, 0,   0, 32'h33, 0, 0,                           4'b0000, 32'h8);
        vt[9]  = mk(0, 0, 0, 0,        0, 0, 0,  0, 3, 0, 0,   0, 32'h33, 0, 0,                           4'b0000, 32'h0);
        // issue and writeback to x4 in one cycle: the set wins
        vt[10] = mk(0, 1, 4, 32'h44,   1, 4, 0,  4, 0, 0, 0,   32'h44, 0, 0, 0,                           4'b0000, 32'h0);
        vt[11] = mk(0, 0, 0, 0,        0, 0, 0,  4, 0, 0, 0,   32'h44, 0, 0, 0,                           4'b0001, 32'h10);
        // flush with issue x5 and write x9: issue dropped, write kept
        vt[12] = mk(0, 1, 9, 32'h55,   1, 5, 1,  9, 4, 0, 0,   32'h55, 32'h44, 0, 0,                      4'b0010, 32'h10);
        vt[13] = mk(0, 0, 0, 0,        0, 0, 0,  9, 4, 5, 0,   32'h55, 32'h44, 0, 0,                      4'b0000, 32'h0);
        // set and clear on different addresses in one cycle
        vt[14] = mk(0, 1, 6, 32'h66,   1, 3, 0,  6, 0, 0, 0,   32'h66, 0, 0, 0,                           4'b0000, 32'h0);
        vt[15] = mk(0, 1, 3, 32'h77,   1, 4, 0,  6, 3, 0, 0,   32'h66, 32'h77, 0, 0,                      4'b0000, 32'h8);
        vt[16] = mk(0, 0, 0, 0,        1, 3, 0,  3, 4, 1, 0,   32'h77, 32'h44, 42, 0,                     4'b0010, 32'h10);

        for (int k = 0; k < NVEC; k++) begin
            @(negedge clk);
            reset = vt[k].rst;
            we3   = vt[k].we3;
            a3    = vt[k].a3;
            wd3   = vt[k].wd3;
            iss   = vt[k].iss;
            iss_a = vt[k].iss_a;
            flush = vt[k].flush;
            ra    = vt[k].ra;
            #1;
            check_outputs($sformatf("vec%0d", k), vt[k].exp_rd, vt[k].exp_busy, vt[k].exp_pend);
        end

        // Async reset between edges: state is x1=42, x3=0x77, x4=0x44, pend={3,4}.
        @(negedge clk);
        we3   = 1'b0;
        iss   = 1'b0;
        flush = 1'b0;
        ra[0] = 5'd1;
        ra[1] = 5'd3;
        ra[2] = 5'd4;
        ra[3] = 5'd0;
        #1;
        e_rd[0] = 42;
        e_rd[1] = 32'h77;
        e_rd[2] = 32'h44;
        e_rd[3] = 0;
        check_outputs("pre_areset", e_rd, 4'b0110, 32'h18);
        reset = 1'b1;
        #1;
        check_outputs("areset_now", '0, 4'b0000, 32'h0);
        #1;
        reset = 1'b0;

        // Nothing survives: stored values are gone after release.
        @(negedge clk);
        ra[0] = 5'd1;
        ra[1] = 5'd7;
        ra[2] = 5'd3;
        ra[3] = 5'd9;
        #1;
        check_outputs("post_areset", '0, 4'b0000, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
